// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - per-destination output FIFO of the 1x3 router with header tagging and packet tracking
module router_fifo #(
    parameter int DEPTH  = 16,
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              read_enb,
    input  logic              lfd_state,
    input  logic [DWIDTH-1:0] data_in,
    output logic              full,
    output logic              empty,
    output logic [DWIDTH-1:0] data_out
);

    localparam logic [AWIDTH:0] FULL_CNT = (AWIDTH+1)'(DEPTH);

    // Entry layout: [DWIDTH] is the header tag, [DWIDTH-1:0] the byte itself
    logic [DWIDTH:0]   mem [DEPTH];
    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;
    logic [AWIDTH:0]   occupancy;
    logic              lfd_d;
    logic [6:0]        pkt_cnt;
    logic              do_wr;
    logic              do_rd;
    logic              flush;
    logic [DWIDTH:0]   rd_entry;

    assign full     = (occupancy == FULL_CNT);
    assign empty    = (occupancy == '0);
    assign flush    = reset || soft_reset;
    // Both strobes are qualified by the flags as they stand at the start of the cycle
    assign do_wr    = write_enb && !full;
    assign do_rd    = read_enb && !empty;
    assign rd_entry = mem[rd_ptr];

    // Delay lfd_state one cycle so the tag lines up with the header on the register stage output
    always_ff @(posedge clock) begin
        if (flush) begin
            lfd_d <= 1'b0;
        end else begin
            lfd_d <= lfd_state;
        end
    end

    // Storage: flush clears every tag bit so stale headers can never be read after a refill
    always_ff @(posedge clock) begin
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i][DWIDTH] <= 1'b0;
            end
        end else if (do_wr) begin
            mem[wr_ptr] <= {lfd_d, data_in};
        end
    end

    // Write/read pointers and occupancy; a simultaneous push and pop leaves occupancy unchanged
    always_ff @(posedge clock) begin
        if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_wr && !do_rd) begin
                occupancy <= occupancy + 1'b1;
            end else if (do_rd && !do_wr) begin
                occupancy <= occupancy - 1'b1;
            end
        end
    end

    // Read side packet tracking: header loads length+1 (payload plus parity), body bytes count down
    always_ff @(posedge clock) begin
        if (flush) begin
            pkt_cnt <= '0;
        end else if (do_rd) begin
            if (rd_entry[DWIDTH]) begin
                pkt_cnt <= {1'b0, rd_entry[7:2]} + 7'd1;
            end else if (pkt_cnt != '0) begin
                pkt_cnt <= pkt_cnt - 7'd1;
            end
        end
    end

    // Registered read data; driven to zero between packets, held while a packet is in progress
    always_ff @(posedge clock) begin
        if (flush) begin
            data_out <= '0;
        end else if (do_rd) begin
            data_out <= rd_entry[DWIDTH-1:0];
        end else if (pkt_cnt == '0) begin
            data_out <= '0;
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// tb/tb_router_fifo.sv - directed self-checking bench for router_fifo
module tb_router_fifo;

    logic       clock = 1'b0;
    logic       reset;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic       full;
    logic       empty;
    logic [7:0] data_out;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    router_fifo dut (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .full       (full),
        .empty      (empty),
        .data_out   (data_out)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] d, input logic hdr);
        if (hdr) begin
            lfd_state = 1'b1;
            tick();
            lfd_state = 1'b0;
        end
        write_enb = 1'b1;
        data_in   = d;
        tick();
        write_enb = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] exp);
        read_enb = 1'b1;
        tick();
        read_enb = 1'b0;
        check(tag, data_out, exp);
    endtask

    initial begin
        reset      = 1'b1;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        lfd_state  = 1'b0;
        data_in    = 8'h00;

        // Reset then idle
        tick();
        tick();
        reset = 1'b0;
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_dout", data_out, 8'h00);
        read_enb = 1'b1;
        tick();
        read_enb = 1'b0;
        check("emptyrd_empty", empty, 1);
        check("emptyrd_dout", data_out, 8'h00);
        check("emptyrd_occ", dut.occupancy, 0);
        check("emptyrd_pkt", dut.pkt_cnt, 0);

        // Single packet: header 0D (len 3), A1 A2 A3, parity 0E
        wr(8'h0D, 1'b1);
        wr(8'hA1, 1'b0);
        wr(8'hA2, 1'b0);
        wr(8'hA3, 1'b0);
        wr(8'h0E, 1'b0);
        check("pkt_occ", dut.occupancy, 5);
        rd("pkt_hdr", 8'h0D);
        check("pkt_cnt_load", dut.pkt_cnt, 4);
        rd("pkt_a1", 8'hA1);
        check("pkt_cnt_3", dut.pkt_cnt, 3);
        rd("pkt_a2", 8'hA2);
        rd("pkt_a3", 8'hA3);
        rd("pkt_par", 8'h0E);
        check("pkt_cnt_0", dut.pkt_cnt, 0);
        tick();
        check("pkt_idle_dout", data_out, 8'h00);
        check("pkt_empty", empty, 1);

        // Fill to full, 17th write dropped
        for (int i = 0; i < 16; i++) wr(8'(i), 1'b0);
        check("fill_full", full, 1);
        check("fill_occ", dut.occupancy, 16);
        wr(8'hFF, 1'b0);
        check("fill_drop_full", full, 1);
        check("fill_drop_occ", dut.occupancy, 16);
        for (int i = 0; i < 16; i++) rd($sformatf("fill_rd%0d", i), 8'(i));
        check("fill_empty", empty, 1);

        // Simultaneous read and write at occupancy 5
        for (int i = 0; i < 5; i++) wr(8'h10 + 8'(i), 1'b0);
        for (int i = 0; i < 4; i++) begin
            write_enb = 1'b1;
            read_enb  = 1'b1;
            data_in   = 8'h15 + 8'(i);
            tick();
            check($sformatf("rw_dout%0d", i), data_out, 8'h10 + 8'(i));
            check($sformatf("rw_occ%0d", i), dut.occupancy, 5);
        end
        write_enb = 1'b0;
        read_enb  = 1'b0;
        for (int i = 0; i < 5; i++) rd($sformatf("rw_drain%0d", i), 8'h14 + 8'(i));
        check("rw_empty", empty, 1);

        // Simultaneous read and write at full: only the read proceeds
        for (int i = 0; i < 16; i++) wr(8'h20 + 8'(i), 1'b0);
        check("rwf_full", full, 1);
        write_enb = 1'b1;
        read_enb  = 1'b1;
        data_in   = 8'hFF;
        tick();
        write_enb = 1'b0;
        read_enb  = 1'b0;
        check("rwf_dout", data_out, 8'h20);
        check("rwf_occ", dut.occupancy, 15);
        check("rwf_notfull", full, 0);
        for (int i = 1; i < 16; i++) rd($sformatf("rwf_drain%0d", i), 8'h20 + 8'(i));
        check("rwf_empty", empty, 1);

        // Wrap-around: three 12-byte packets, header 29 = len 10 addr 1
        for (int k = 0; k < 3; k++) begin
            wr(8'h29, 1'b1);
            for (int i = 0; i < 10; i++) wr(8'h40 + 8'(k * 16 + i), 1'b0);
            wr(8'h5A + 8'(k), 1'b0);
            check($sformatf("wrap_occ%0d", k), dut.occupancy, 12);
            rd($sformatf("wrap_hdr%0d", k), 8'h29);
            check($sformatf("wrap_cnt%0d", k), dut.pkt_cnt, 11);
            for (int i = 0; i < 10; i++)
                rd($sformatf("wrap_p%0d_%0d", k, i), 8'h40 + 8'(k * 16 + i));
            rd($sformatf("wrap_par%0d", k), 8'h5A + 8'(k));
            check($sformatf("wrap_cnt0_%0d", k), dut.pkt_cnt, 0);
        end
        check("wrap_empty", empty, 1);

        // Soft reset mid-packet with a concurrent write
        wr(8'h14, 1'b1);
        wr(8'hB1, 1'b0);
        wr(8'hB2, 1'b0);
        rd("sr_hdr", 8'h14);
        check("sr_cnt", dut.pkt_cnt, 6);
        rd("sr_b1", 8'hB1);
        soft_reset = 1'b1;
        write_enb  = 1'b1;
        data_in    = 8'hCC;
        tick();
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        check("sr_empty", empty, 1);
        check("sr_dout", data_out, 8'h00);
        check("sr_occ", dut.occupancy, 0);
        check("sr_pkt", dut.pkt_cnt, 0);

        // Fresh packet after flush: header 08 (len 2), C1 C2, parity 0A
        wr(8'h08, 1'b1);
        wr(8'hC1, 1'b0);
        wr(8'hC2, 1'b0);
        wr(8'h0A, 1'b0);
        check("np_occ", dut.occupancy, 4);
        rd("np_hdr", 8'h08);
        check("np_cnt", dut.pkt_cnt, 3);
        rd("np_c1", 8'hC1);
        rd("np_c2", 8'hC2);
        rd("np_par", 8'h0A);
        check("np_cnt0", dut.pkt_cnt, 0);
        tick();
        check("np_idle", data_out, 8'h00);
        check("np_empty", empty, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
